// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, RV32I
// load/store size encodings and the access legality check.
package DmemPkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Misaligned accesses, reserved sizes and zero-extending stores are errors.
  function automatic logic access_error(input logic [2:0] func3,
                                        input logic [1:0] addr_lo,
                                        input logic       is_write);
    logic err;
    case (func3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr_lo[0];
      F3_W:    err = |addr_lo;
      F3_BU:   err = is_write;
      F3_HU:   err = is_write | addr_lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_responder_byte_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a
// registered read port (read-before-write).
module dmem_byte_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one load/store, stalls the
// pipeline for WAIT_CYCLES wait states, then pulses a one-cycle response.
module dmem_responder
  import DmemPkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state, next_state;
  logic [3:0]    cnt;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    func3_q;
  logic          write_q;
  logic          rsp_valid_q, rsp_err_q;

  logic          req_any, enter_resp;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata, wr_data, ram_rdata, ext_data;
  logic [2:0]    acc_func3;
  logic          acc_write, acc_err, ram_en;
  logic [3:0]    be;
  logic [15:0]   lane;
  logic          unused_addr_hi;

  assign req_any        = req_read | req_write;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  // With zero wait states the array access happens on the capture edge,
  // so the live request is used there instead of the request registers.
  assign acc_addr   = (state == IDLE) ? req_addr[AW+1:0] : addr_q;
  assign acc_wdata  = (state == IDLE) ? req_wdata        : wdata_q;
  assign acc_func3  = (state == IDLE) ? req_func3        : func3_q;
  assign acc_write  = (state == IDLE) ? req_write        : write_q;
  assign acc_err    = access_error(acc_func3, acc_addr[1:0], acc_write);
  assign enter_resp = (state != RESP) && (next_state == RESP);
  assign ram_en     = rst_n && enter_resp && !acc_err;

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        stall = req_any;
        if (req_any) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd1) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      func3_q     <= '0;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state       <= next_state;
      rsp_valid_q <= enter_resp;
      if (state == IDLE && req_any) begin
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
        func3_q <= req_func3;
        write_q <= req_write;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) rsp_err_q <= acc_err;
    end
  end

  // Replicate store data across lanes; byte enables pick the addressed ones.
  always_comb begin
    wr_data = acc_wdata;
    be      = 4'b1111;
    case (acc_func3[1:0])
      2'b00: begin
        wr_data = {4{acc_wdata[7:0]}};
        be      = 4'b0001 << acc_addr[1:0];
      end
      2'b01: begin
        wr_data = {2{acc_wdata[15:0]}};
        be      = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  dmem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (acc_write),
    .be    (be),
    .addr  (acc_addr[AW+1:2]),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

  assign lane = 16'(ram_rdata >> {addr_q[1:0], 3'b000});

  always_comb begin
    ext_data = ram_rdata;
    case (func3_q)
      F3_B:    ext_data = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   ext_data = {24'h0, lane[7:0]};
      F3_H:    ext_data = {{16{lane[15]}}, lane};
      F3_HU:   ext_data = {16'h0, lane};
      default: ext_data = ram_rdata;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = (rsp_valid_q && !rsp_err_q && !write_q) ? ext_data : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (2 and 0 wait states)
// compared against a byte-level memory model and per-cycle handshake timing.
module tb_dmem_responder;
  import DmemPkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;

  logic        a_stall, a_valid, a_err, b_stall, b_valid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        o_stall, o_valid, o_err;
  logic [31:0] o_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] model_bytes [2][4096];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_read  (req_read  & ~sel),
    .req_write (req_write & ~sel),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_func3 (req_func3),
    .stall     (a_stall),
    .rsp_valid (a_valid),
    .rsp_rdata (a_rdata),
    .rsp_err   (a_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_read  (req_read  & sel),
    .req_write (req_write & sel),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_func3 (req_func3),
    .stall     (b_stall),
    .rsp_valid (b_valid),
    .rsp_rdata (b_rdata),
    .rsp_err   (b_err)
  );

  assign o_stall = sel ? b_stall : a_stall;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_rdata = sel ? b_rdata : a_rdata;
  assign o_err   = sel ? b_err   : a_err;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Byte-level model: memory is 4 KiB per instance, addresses alias modulo 4096.
  function automatic void model_access(input int d, input bit wr, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [2:0] f3,
                                       output logic [31:0] rd, output bit err);
    int nbytes;
    int base;
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: nbytes = 1;
      3'd1, 3'd5: nbytes = 2;
      3'd2:       nbytes = 4;
      default:    nbytes = 0;
    endcase
    err = (nbytes == 0) || (wr && f3 >= 3'd4) || ((nbytes != 0) && (addr % nbytes != 0));
    rd  = 32'h0;
    if (err) return;
    base = int'(addr & 32'hFFF);
    if (wr) begin
      for (int i = 0; i < nbytes; i++) model_bytes[d][base + i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(model_bytes[d][base + i]) << (8*i));
      if (f3 < 3'd4 && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
      rd = v;
    end
  endfunction

  // One complete access on the selected instance with cycle-by-cycle checks.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3,
                               input string tag, output logic [31:0] got_rdata);
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          w;
    w = sel ? 0 : 2;
    model_access(sel ? 1 : 0, wr, addr, wdata, f3, exp_rdata, exp_err);
    @(posedge clk); #1;
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata; req_func3 = f3;
    #1;
    for (int c = 0; c <= w; c++) begin
      checkOutput({tag, "_stall"}, {30'h0, o_stall, o_valid}, 32'h2);
      @(posedge clk); #2;
    end
    checkOutput({tag, "_resp"}, {30'h0, o_stall, o_valid}, 32'h1);
    checkOutput({tag, "_rdata"}, o_rdata, exp_rdata);
    checkOutput({tag, "_err"}, {31'h0, o_err}, {31'h0, exp_err});
    got_rdata = o_rdata;
    req_read = 1'b0; req_write = 1'b0;
    @(posedge clk); #2;
    checkOutput({tag, "_idle"}, {30'h0, o_stall, o_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] got, exp_rd;
    bit          exp_e;
    bit          rd, wr;
    logic [31:0] addr;

    sel = 1'b0; rst_n = 1'b0;
    req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_func3 = '0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_a", {a_stall, a_valid, a_err, a_rdata[28:0]}, 32'h0);
    checkOutput("reset_a_rdata", a_rdata, 32'h0);
    checkOutput("reset_b", {b_stall, b_valid, b_err, b_rdata[28:0]}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Give every word in the test window a known value (random alias bits).
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 1, (32'(i) * 4) | ($urandom & 32'hFFFF_F000), $urandom, F3_W, "init", got);

    applyStimulus(0, 1, 32'h10, 32'hDEADBEEF, F3_W, "sw_10", got);
    applyStimulus(1, 0, 32'h10, 32'h0, F3_W, "lw_10", got);
    checkOutput("lw_10_const", got, 32'hDEADBEEF);
    applyStimulus(0, 1, 32'h13, 32'h80, F3_B, "sb_13", got);
    applyStimulus(1, 0, 32'h13, 32'h0, F3_B, "lb_13", got);
    checkOutput("lb_13_const", got, 32'hFFFFFF80);
    applyStimulus(1, 0, 32'h13, 32'h0, F3_BU, "lbu_13", got);
    checkOutput("lbu_13_const", got, 32'h00000080);
    applyStimulus(1, 0, 32'h10, 32'h0, F3_W, "lw_10b", got);
    checkOutput("lw_10b_const", got, 32'h80ADBEEF);
    applyStimulus(1, 0, 32'h11, 32'h0, F3_H, "lh_mis", got);
    applyStimulus(0, 1, 32'h12, 32'h11111111, F3_W, "sw_mis", got);
    applyStimulus(1, 0, 32'h10, 32'h0, F3_W, "lw_after_mis", got);
    checkOutput("lw_after_mis_const", got, 32'h80ADBEEF);
    applyStimulus(1, 0, 32'h10, 32'h0, 3'b011, "f3_011", got);
    applyStimulus(1, 1, 32'h14, 32'h0BADF00D, F3_W, "rw_both", got);
    applyStimulus(1, 0, 32'h14, 32'h0, F3_W, "lw_14", got);
    checkOutput("lw_14_const", got, 32'h0BADF00D);

    // Reset while the store to 0x20 is waiting: it must be dropped.
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_func3 = F3_W;
    #1;
    checkOutput("rst_wait_c0", {31'h0, a_stall}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0; req_write = 1'b0;
    #1;
    checkOutput("rst_wait_c1", {30'h0, a_stall, a_valid}, 32'h2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_wait_c2", {30'h0, a_stall, a_valid}, 32'h0);
    repeat (2) begin
      @(posedge clk); #2;
      checkOutput("rst_wait_novalid", {30'h0, a_stall, a_valid}, 32'h0);
    end
    applyStimulus(1, 0, 32'h20, 32'h0, F3_W, "lw_20_after_rst", got);

    applyStimulus(0, 1, 32'h1000, 32'hA5A5A5A5, F3_W, "sw_alias", got);
    applyStimulus(1, 0, 32'h0, 32'h0, F3_W, "lw_alias", got);
    checkOutput("lw_alias_const", got, 32'hA5A5A5A5);

    for (int i = 0; i < 40; i++) begin
      rd   = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      addr = 32'($urandom_range(0, 63)) | ($urandom & 32'hFFFF_F000);
      applyStimulus(rd, wr, addr, $urandom, 3'($urandom_range(0, 7)), "rand", got);
    end

    // Zero-wait-state instance: two loads held back to back.
    sel = 1'b1;
    applyStimulus(0, 1, 32'h8, 32'hCAFEF00D, F3_W, "b_sw_8", got);
    applyStimulus(0, 1, 32'hC, 32'h13572468, F3_W, "b_sw_c", got);
    @(posedge clk); #1;
    req_read = 1'b1; req_addr = 32'h8; req_func3 = F3_W;
    #1;
    checkOutput("b2b_c0", {30'h0, b_stall, b_valid}, 32'h2);
    @(posedge clk); #2;
    model_access(1, 0, 32'h8, 32'h0, F3_W, exp_rd, exp_e);
    checkOutput("b2b_c1", {30'h0, b_stall, b_valid}, 32'h1);
    checkOutput("b2b_c1_rdata", b_rdata, exp_rd);
    req_addr = 32'hC;
    #1;
    @(posedge clk); #2;
    checkOutput("b2b_c2", {30'h0, b_stall, b_valid}, 32'h2);
    @(posedge clk); #2;
    model_access(1, 0, 32'hC, 32'h0, F3_W, exp_rd, exp_e);
    checkOutput("b2b_c3", {30'h0, b_stall, b_valid}, 32'h1);
    checkOutput("b2b_c3_rdata", b_rdata, exp_rd);
    checkOutput("b2b_c3_const", b_rdata, 32'h13572468);
    req_read = 1'b0;
    @(posedge clk); #2;
    checkOutput("b2b_c4", {30'h0, b_stall, b_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far end of the MEM-stage request interface. Accepts the load/store the MEM stage drives from its pipeline state (MemRead, MemWrite, ALUOutput address, rd2 store data, func3 size), performs it against an internal byte-addressable word array after a fixed number of wait states, and returns load data to the MEM/WB boundary. While an access is in flight it holds the pipeline with `stall`.

## Interface
- `DEPTH_WORDS`, 1024: array depth in 32-bit words, power of two.
- `WAIT_CYCLES`, 2: extra wait states per access, 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `req_read`  in  1  MEM-stage MemRead.
- `req_write`  in  1  MEM-stage MemWrite.
- `req_addr`  in  32  byte address (ALUOutput).
- `req_wdata`  in  32  store data (rd2), right-aligned.
- `req_func3`  in  3  access size/sign, RV32I load/store encoding.
- `stall`  out  1  freeze IF..MEM pipeline registers this cycle.
- `rsp_valid`  out  1  one-cycle pulse: access complete.
- `rsp_rdata`  out  32  load result, extended per func3; 0 for stores and errors.
- `rsp_err`  out  1  valid with `rsp_valid`: misaligned or illegal func3.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `stall = req_read | req_write` (combinational). On a request, capture addr/wdata/func3/kind into request registers, load counter with `WAIT_CYCLES`; go to WAIT if `WAIT_CYCLES>0`, else RESP.
- WAIT: `stall=1`; counter decrements each cycle; on counter==1 go to RESP.
- Edge into RESP: store committed to array / load word sampled, using captured request only.
- RESP: `stall=0`, `rsp_valid=1`, `rsp_rdata`/`rsp_err` registered and valid; next state IDLE unconditionally (the still-present request is never re-accepted).
- Both `req_read` and `req_write` high: treated as a write.
- Sizes: 000 byte signed, 001 half signed, 010 word, 100 byte zero-ext, 101 half zero-ext. Stores use 000/001/010 only, with byte enables on the addressed lanes; little-endian.
- Errors: half with addr[0]=1, word with addr[1:0]≠0, func3 ∈ {011,110,111}, or store func3 ∈ {100,101}: full timing preserved, no array write, `rsp_err=1`, `rsp_rdata=0`.
- Word index = `req_addr[2 +: log2(DEPTH_WORDS)]`; higher address bits ignored (aliasing, no error).

## Timing
- Reset: state IDLE, counter 0, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`; `stall` follows IDLE rule. Array contents not reset.
- Request first seen in cycle 0: `stall` high cycles 0..`WAIT_CYCLES`, `rsp_valid` in cycle `WAIT_CYCLES+1`; pipeline advances on that edge.
- `WAIT_CYCLES=0`: one stall cycle, response next cycle.
- Back-to-back accesses: next request accepted in the IDLE cycle after RESP; throughput one access per `WAIT_CYCLES+2` cycles.
- Request inputs may change during WAIT; they are ignored.
- `rst_n` low in WAIT or RESP: return to IDLE next edge, pending store dropped, no `rsp_valid`.

## Structure
- Shared package `DmemPkg`: state enum (IDLE/WAIT/RESP), func3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
- Sub-module `dmem_byte_ram`: `DEPTH_WORDS`×32 synchronous array, 4-bit byte enable, registered read.
- Top holds FSM, counter, request registers, lane steering, error check, load extension.

## Test plan
- `WAIT_CYCLES=2`: SW 0xDEADBEEF @0x10, then LW @0x10 -> stall 3 cycles each, rsp_valid on cycle 3, rdata 0xDEADBEEF, err 0.
- SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
- LH @0x11 -> err 1, rdata 0; SW @0x12 -> err 1, word @0x10 unchanged; func3=011 -> err 1.
- `WAIT_CYCLES=0`: two consecutive LWs -> stall 1 cycle each, rsp_valid cycles 1 and 3, no double acceptance.
- `rst_n` low in WAIT of SW 0x12345678 @0x20 -> no rsp_valid, IDLE next cycle; later LW @0x20 returns prior contents.
- `DEPTH_WORDS=1024`: SW 0xA5A5A5A5 @0x1000, then LW @0x0 -> 0xA5A5A5A5 (aliasing).
